// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared register offsets, STATUS bit indices and shifter states
//               for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_off_data   = 2'd0;
    localparam logic [1:0] c_off_status = 2'd1;
    localparam logic [1:0] c_off_div    = 2'd2;
    localparam logic [1:0] c_off_rsvd   = 2'd3;

    localparam int c_stat_busy  = 0;
    localparam int c_stat_full  = 1;
    localparam int c_stat_empty = 2;
    localparam int c_stat_ovf   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // A divisor below 2 cannot produce a meaningful bit period.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < 16'd2) ? 16'd2 : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : DEPTH x 8 transmit FIFO with a registered head output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int c_aw = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [7:0]      r_head;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic [c_aw-1:0] w_rd_next;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_head;
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;
    assign w_rd_next = r_rd_ptr + c_aw'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop_ok)  r_rd_ptr <= w_rd_next;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
            // Head tracks the entry that will be at the read pointer next cycle.
            if (w_pop_ok) begin
                if (r_count > (c_aw+1)'(1)) r_head <= r_mem[w_rd_next];
                else if (w_push_ok)         r_head <= din;
            end else if (empty && w_push_ok) begin
                r_head <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Memory-mapped 8N1 UART transmitter with divisor register,
//               status register and transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010,
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        rw_req,
    input  logic        rw,
    input  logic [31:0] write_data,
    input  logic [1:0]  size,
    output logic [31:0] read_data,
    output logic        prec,
    output logic        sout
);

    tx_state_e   r_state;
    tx_state_e   w_next_state;
    logic [15:0] r_div;
    logic [15:0] r_frame_div;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_overflow;
    logic        r_prec;
    logic [31:0] r_read_data;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_status_rd;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_head;
    logic [31:0] w_status;
    logic [31:0] w_rd_value;
    logic        w_unused;

    assign w_sel       = rw_req && (address[31:4] == BASE_ADDR[31:4]);
    assign w_off       = address[3:2];
    assign w_push      = w_sel && rw && (w_off == c_off_data);
    assign w_status_rd = w_sel && !rw && (w_off == c_off_status);
    assign w_drop      = w_push && w_fifo_full && !w_pop;
    assign w_unused    = &{1'b0, address[1:0], write_data[31:16]};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (write_data[7:0]),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_fifo_head)
    );

    always_comb begin
        w_status               = 32'h0;
        w_status[c_stat_busy]  = (r_state != ST_IDLE);
        w_status[c_stat_full]  = w_fifo_full;
        w_status[c_stat_empty] = w_fifo_empty;
        w_status[c_stat_ovf]   = r_overflow;
        w_rd_value             = 32'h0;
        if (w_sel && !rw) begin
            case (w_off)
                c_off_status: w_rd_value = w_status;
                c_off_div:    w_rd_value = {16'h0, r_div};
                c_off_data,
                c_off_rsvd:   w_rd_value = 32'h0;
                default:      w_rd_value = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prec      <= 1'b0;
            r_read_data <= 32'h0;
            r_overflow  <= 1'b0;
            r_div       <= DIV_RESET;
        end else begin
            r_prec      <= w_sel;
            r_read_data <= w_rd_value;
            // A drop in the same cycle as a STATUS read must not be lost.
            if (w_drop)           r_overflow <= 1'b1;
            else if (w_status_rd) r_overflow <= 1'b0;
            if (w_sel && rw && (w_off == c_off_div) && (size == 2'b10)) begin
                r_div <= clamp_div(write_data[15:0]);
            end
        end
    end

    assign prec      = r_prec;
    assign read_data = r_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: if (r_timer == 16'd0) w_next_state = ST_DATA;
            ST_DATA:  if (r_timer == 16'd0 && r_bit_cnt == 3'd7) w_next_state = ST_STOP;
            ST_STOP:  if (r_timer == 16'd0) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Bit timer and shifter; the divisor is frozen per frame in r_frame_div.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer     <= 16'd0;
            r_frame_div <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift     <= w_fifo_head;
                        r_frame_div <= r_div;
                        r_timer     <= r_div - 16'd1;
                        r_bit_cnt   <= 3'd0;
                    end
                end
                ST_START: begin
                    if (r_timer == 16'd0) r_timer <= r_frame_div - 16'd1;
                    else                  r_timer <= r_timer - 16'd1;
                end
                ST_DATA: begin
                    if (r_timer == 16'd0) begin
                        r_timer   <= r_frame_div - 16'd1;
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == 16'd0) r_timer <= 16'd0;
                    else                  r_timer <= r_timer - 16'd1;
                end
                default: r_timer <= 16'd0;
            endcase
        end
    end

    always_comb begin
        sout = 1'b1;
        case (r_state)
            ST_START: sout = 1'b0;
            ST_DATA:  sout = r_shift[0];
            default:  sout = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx; serial output is compared
//               against a per-clock line model built from the 8N1 frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam logic [31:0] c_base = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        rw_req;
    logic        rw;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic [31:0] read_data;
    logic        prec;
    logic        sout;

    int errors = 0;
    int checks = 0;

    uart_tx u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .rw_req     (rw_req),
        .rw         (rw),
        .write_data (write_data),
        .size       (size),
        .read_data  (read_data),
        .prec       (prec),
        .sout       (sout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: request held for one cycle, response sampled the next.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] sz, output logic [31:0] rd, output logic p);
        @(negedge clk);
        address = a; rw = w; write_data = d; size = sz; rw_req = 1'b1;
        @(negedge clk);
        rw_req = 1'b0;
        rd = read_data;
        p  = prec;
    endtask

    // Line model: start bit, 8 data bits LSB first, stop bit, then one idle clock.
    function automatic logic line_bit(input logic [7:0] b, input int i, input int div);
        int k;
        k = i / div;
        if (i >= 10 * div) return 1'b1;
        if (k == 0)        return 1'b0;
        if (k == 9)        return 1'b1;
        return b[k-1];
    endfunction

    task automatic check_stream(input logic [7:0] b [8], input int n, input int div);
        int waited;
        waited = 0;
        @(negedge clk);
        while (sout !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("frame_start_seen", 32'(waited < 400), 32'd1);
        if (waited < 400) begin
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < 10 * div + 1; i++) begin
                    check($sformatf("sout_byte%0d_clk%0d", k, i), 32'(sout), 32'(line_bit(b[k], i, div)));
                    @(negedge clk);
                end
            end
        end
    endtask

    logic [31:0] rd;
    logic        p;
    logic [7:0]  bytes [8];
    logic [7:0]  b;
    int          div;
    int          n;
    int          lows;

    initial begin
        reset = 1'b1; address = 32'h0; rw_req = 1'b0; rw = 1'b0;
        write_data = 32'h0; size = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_sout", 32'(sout), 32'd1);
        check("reset_prec", 32'(prec), 32'd0);
        check("reset_rdata", read_data, 32'h0);
        reset = 1'b0;

        bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
        check("status_after_reset", rd, 32'h4);
        check("status_prec", 32'(p), 32'd1);
        @(negedge clk);
        check("prec_one_cycle", 32'(prec), 32'd0);
        check("rdata_zero_no_prec", read_data, 32'h0);
        bus(c_base + 32'd8, 1'b0, 32'h0, 2'b10, rd, p);
        check("div_after_reset", rd, 32'd434);

        // Decode: out-of-window accesses are invisible.
        bus(c_base + 32'd16, 1'b0, 32'h0, 2'b10, rd, p);
        check("oow_read_prec", 32'(p), 32'd0);
        check("oow_read_rdata", rd, 32'h0);
        bus(32'h0000_0010, 1'b1, 32'hA5, 2'b10, rd, p);
        check("oow_write_prec", 32'(p), 32'd0);
        repeat (3) @(negedge clk);
        check("oow_write_sout", 32'(sout), 32'd1);
        bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
        check("oow_status", rd, 32'h4);

        // Registers.
        bus(c_base + 32'd8, 1'b1, 32'h0001, 2'b10, rd, p);
        check("div_write_prec", 32'(p), 32'd1);
        bus(c_base + 32'd8, 1'b0, 32'h0, 2'b10, rd, p);
        check("div_clamped", rd, 32'h2);
        bus(c_base + 32'd8, 1'b1, 32'h0055, 2'b00, rd, p);
        bus(c_base + 32'd8, 1'b0, 32'h0, 2'b10, rd, p);
        check("div_size_ignored", rd, 32'h2);
        bus(c_base + 32'd12, 1'b1, 32'hFFFF_FFFF, 2'b10, rd, p);
        check("rsvd_write_prec", 32'(p), 32'd1);
        bus(c_base + 32'd12, 1'b0, 32'h0, 2'b10, rd, p);
        check("rsvd_read", rd, 32'h0);
        check("rsvd_read_prec", 32'(p), 32'd1);
        bus(c_base + 32'd0, 1'b0, 32'h0, 2'b10, rd, p);
        check("data_read", rd, 32'h0);

        // Single 0x55 frame with exact latency from the write.
        bus(c_base + 32'd8, 1'b1, 32'd4, 2'b10, rd, p);
        bus(c_base + 32'd0, 1'b1, 32'h55, 2'b00, rd, p);
        check("latency_still_idle", 32'(sout), 32'd1);
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            check($sformatf("frame55_clk%0d", i), 32'(sout), 32'(line_bit(8'h55, i, 4)));
        end

        // Overflow: six back-to-back writes while the stream is monitored.
        for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 6; i++) begin
                    address = c_base; rw = 1'b1; write_data = 32'(i + 1); size = 2'b00;
                    rw_req = 1'b1;
                    @(negedge clk);
                    check($sformatf("b2b_prec%0d", i), 32'(prec), 32'd1);
                end
                rw_req = 1'b0;
                bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
                check("ovf_status_1", rd, 32'hB);
                bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
                check("ovf_status_2", rd, 32'h3);
            end
            check_stream(bytes, 5, 4);
        join
        repeat (5) @(negedge clk);

        // Random divisors and payloads.
        for (int r = 0; r < 3; r++) begin
            div = int'($urandom_range(2, 5));
            n   = int'($urandom_range(1, 4));
            for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
            bus(c_base + 32'd8, 1'b1, 32'(div), 2'b10, rd, p);
            bus(c_base + 32'd8, 1'b0, 32'h0, 2'b10, rd, p);
            check($sformatf("rand_div%0d", r), rd, 32'(div));
            fork
                for (int i = 0; i < n; i++) bus(c_base, 1'b1, {24'h0, bytes[i]}, 2'b00, rd, p);
                check_stream(bytes, n, div);
            join
            bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
            check($sformatf("rand_idle%0d", r), rd, 32'h4);
        end

        // Reset in the middle of data bit 3, with a second byte queued.
        bus(c_base + 32'd8, 1'b1, 32'd4, 2'b10, rd, p);
        b = 8'($urandom) & 8'hF7;
        bus(c_base, 1'b1, {24'h0, b}, 2'b00, rd, p);
        bus(c_base, 1'b1, 32'hFF, 2'b00, rd, p);
        repeat (16) @(negedge clk);
        check("pre_reset_bit3", 32'(sout), 32'd0);
        reset = 1'b1;
        #1;
        check("reset_async_sout", 32'(sout), 32'd1);
        @(negedge clk);
        check("reset_prec_mid", 32'(prec), 32'd0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sout !== 1'b1) lows++;
        end
        check("post_reset_line_idle", 32'(lows), 32'd0);
        bus(c_base + 32'd4, 1'b0, 32'h0, 2'b10, rd, p);
        check("post_reset_status", rd, 32'h4);
        bus(c_base + 32'd8, 1'b0, 32'h0, 2'b10, rd, p);
        check("post_reset_div", rd, 32'd434);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BASE_ADDR, 32'h8000_0010: register window base; window is BASE_ADDR..BASE_ADDR+15.
REQ-002 Parameter DIV_RESET, 16'd434: baud divisor after reset, in clocks per bit.
REQ-003 Parameter FIFO_DEPTH, 4: transmit FIFO entries, power of two.
REQ-004 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port address, input, 32: bus address from CPU.
REQ-007 Port rw_req, input, 1: one-cycle transaction request strobe.
REQ-008 Port rw, input, 1: 1 = write, 0 = read; sampled with rw_req.
REQ-009 Port write_data, input, 32: write payload; sampled with rw_req.
REQ-010 Port size, input, 2: access size; ignored except as noted in REQ-018.
REQ-011 Port read_data, output, 32: read result; valid only while prec=1.
REQ-012 Port prec, output, 1: one-cycle acknowledge for a decoded request.
REQ-013 Port sout, output, 1: serial line, idle high.

Function
REQ-014 Decode: request selected when rw_req=1 and address[31:4]==BASE_ADDR[31:4]; offset = address[3:2]; unselected requests produce no prec and no side effects.
REQ-015 Handshake: selected request in cycle N -> prec=1 in cycle N+1 only; read_data=32'h0 whenever prec=0.
REQ-016 Offset 0 (DATA): write pushes write_data[7:0] into FIFO; read returns 0.
REQ-017 Offset 1 (STATUS), read-only: bit0 busy (shifter not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky); other bits 0; reading clears overflow in the same cycle prec asserts.
REQ-018 Offset 2 (DIV): write loads write_data[15:0] only when size==2'b10, otherwise ignored; values <2 stored as 2; read returns {16'h0, DIV}.
REQ-019 Offset 3: reads 0, writes ignored, prec still asserted.
REQ-020 Push when FIFO full and no pop in the same cycle: data dropped, overflow=1; prec still asserted.
REQ-021 Push and pop in the same cycle: both succeed, including when full.
REQ-022 Shifter FSM states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-023 IDLE: sout=1; when FIFO is non-empty, pop the head, latch it and the current DIV, and go to START on the next cycle.
REQ-024 START: sout=0 for DIV clocks; DATA: 8 bits of DIV clocks each; STOP: sout=1 for DIV clocks, then IDLE.
REQ-025 Bit timer counts DIV-1 down to 0; it reloads on every state entry.
REQ-026 A DIV write mid-frame takes effect at the next frame only.
REQ-027 Back-to-back frames: STOP exits straight to IDLE; the next START begins 1 clock later if the FIFO is non-empty (minimum frame period 10*DIV+1 clocks).
REQ-028 Latency: DATA write in cycle N with FIFO empty and FSM IDLE -> sout falls at cycle N+2.

Reset
REQ-029 While reset=1, asynchronously: sout=1, prec=0, read_data=0, FSM=IDLE, FIFO empty, overflow=0, DIV=DIV_RESET, timers=0.
REQ-030 Reset mid-frame aborts the frame immediately; sout returns high without completing the stop bit; queued data is discarded.

Structure
REQ-031 Shared package uart_pkg holds the register offset constants, STATUS bit indices and the FSM state enum.
REQ-032 The FIFO is a sub-module uart_fifo: FIFO_DEPTH x 8, with push, pop, full, empty and data ports, and a registered head output.
REQ-033 Decode, registers, bit timer and FSM live in uart_tx; no other sub-modules.

Verification
REQ-034 Frame: DIV=4, write DATA 0x55 -> sout low 4 clocks from N+2, then bits 1,0,1,0,1,0,1,0 (4 clocks each), then high 4 clocks; frame is 40 clocks.
REQ-035 Overflow: DIV=4, six back-to-back DATA writes 0x01..0x06 -> 0x01..0x05 transmitted in order; 0x06 lost; STATUS read returns bit3=1 and a second read returns bit3=0.
REQ-036 Registers: write DIV 16'h0001 with size=2'b10 -> DIV reads 16'h0002; write with size=2'b00 -> DIV unchanged.
REQ-037 Decode: read at BASE_ADDR+16 and write at 32'h0000_0010 -> prec stays 0 and state is unchanged; read at BASE_ADDR+4 when idle and empty -> read_data=32'h4, prec high exactly 1 cycle.
REQ-038 Reset: assert reset during DATA bit 3 of a frame -> sout=1 within the same cycle; after release, STATUS=32'h4 and DIV=DIV_RESET.
